writeback: RTL
==============

# writeback

Final pipeline stage: consumes the 181-bit EX_WB bus from the execute stage, registers it, and commits results into a 32 x 32-bit register file. Two combinational read ports with same-cycle write bypass serve the decode stage. Also tracks halt state and a retired-instruction counter for the bench and debug.

## Interface
Parameters:
- DATA_W, 32, register and result width
- NREGS, 32, register count; address width is 5

Ports:
- clock  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- EX_WB  in  181  execute result bus: [31:0] result, [36:32] dest address, [37] write enable, [38] halt, [39] valid, [180:40] ignored
- rd_addr_a  in  5  read port A address (decode)
- rd_addr_b  in  5  read port B address (decode)
- rd_data_a  out  32  read port A data
- rd_data_b  out  32  read port B data
- wb_valid  out  1  registered stage valid (forwarding source for decode)
- wb_addr  out  5  registered dest address
- wb_data  out  32  registered result
- halted  out  1  high once a halt has committed
- retired  out  32  count of committed valid instructions

## Operation
- Stage register: each edge captures EX_WB[39:0] into wb_q (valid, halt, we, addr, data). Exception: while halted, the captured valid is forced to 0.
- Commit: on the edge after capture, if wb_q.valid & wb_q.we & wb_q.addr != 0, the register file is written: regs[wb_q.addr] <= wb_q.data.
- Register 0 reads as 0 and is never written. A write to r0 still counts as retired.
- Read ports are combinational: addr 0 -> 0. If addr == wb_q.addr and wb_q.valid & wb_q.we and addr != 0, the port returns wb_q.data (bypass). Otherwise it returns regs[addr]. Both ports bypass independently, and both may hit the same address.
- retired increments by 1 on each commit edge where wb_q.valid = 1, including halt and non-writing instructions. Wraps 0xFFFFFFFF -> 0.
- State machine, two states:
  - RUN -> HALTED on a commit edge where wb_q.valid & wb_q.halt. The halt instruction itself commits: its write happens if we = 1, and retired counts it.
  - HALTED: no further register writes and retired is frozen. Incoming EX_WB is ignored. Read ports remain functional.
  - The only exit from HALTED is reset.
- wb_valid/wb_addr/wb_data are direct views of wb_q.

## Timing
- Result presented on EX_WB before edge N: captured at edge N (visible on wb_* after N); committed to regs at edge N+1.
- Read-after-write: a read of the dest address returns the new data from after edge N onward, via bypass until N+1 and from regs after that. There is no stall cycle.
- Back-to-back writes to the same address on consecutive cycles: the later one wins. Bypass always reflects the youngest entry in wb_q.
- halted rises after the edge that commits the halt (edge N+1 for a halt presented before edge N).
- A valid instruction presented in the same cycle that halted rises is dropped.
- Reset, asynchronous when driven low:
  - wb_q cleared (valid = 0, addr = 0, data = 0).
  - All regs cleared to 0.
  - retired = 0, halted = 0, state = RUN.
  - rd_data_a/b = 0 for every address.
- Reset asserted mid-pipeline discards any uncommitted wb_q entry. On release, the first capture occurs at the first rising edge with reset high.

## Test plan
- Reset: drive reset low mid-run with regs populated -> halted = 0, retired = 0, wb_valid = 0, and reads of r1..r31 return 0 immediately, without waiting for an edge.
- Basic write: EX_WB = {valid = 1, we = 1, addr = 5, data = 0xDEADBEEF} for one cycle -> after edge N, wb_data = 0xDEADBEEF and rd_addr_a = 5 reads 0xDEADBEEF via bypass. After N+1, same value from regs; retired = 1.
- r0 guard: write 0x12345678 to addr 0 -> rd_data_a at addr 0 stays 0 throughout; retired increments.
- Back-to-back same address: addr 7 gets 0x1 then 0x2 on consecutive cycles, with both ports on addr 7 -> reads 0x1 for one cycle, then 0x2 from then on.
- Invalid and non-writing entries:
  - valid = 0, we = 1, addr 3 -> r3 unchanged, retired unchanged.
  - valid = 1, we = 0 -> r3 unchanged, retired + 1.
- Halt: halt instruction with we = 1, addr 9, data 0xAA, followed by writes to addr 10 -> r9 = 0xAA, halted = 1, retired counts the halt. r10 stays 0 and retired stays frozen until reset; after reset, writes work again.

Source files
------------

// File: rtl/writeback_if.sv
// Execute-to-writeback bus plus decode read ports and debug status of the writeback stage.
interface writeback_if;
  logic [180:0] EX_WB;
  logic [4:0]   rd_addr_a;
  logic [4:0]   rd_addr_b;
  logic [31:0]  rd_data_a;
  logic [31:0]  rd_data_b;
  logic         wb_valid;
  logic [4:0]   wb_addr;
  logic [31:0]  wb_data;
  logic         halted;
  logic [31:0]  retired;

  modport master (
    output EX_WB, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wb_valid, wb_addr, wb_data, halted, retired
  );

  modport slave (
    input  EX_WB, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wb_valid, wb_addr, wb_data, halted, retired
  );
endinterface

// File: rtl/writeback.sv
// Final pipeline stage: registers the EX_WB bus, commits into the register file,
// serves two bypassed read ports and tracks halt / retired-instruction count.
module writeback #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic        clock,
  input  logic        reset,
  writeback_if.slave  bus
);
  localparam int unsigned AW = $clog2(NREGS);

  typedef struct packed {
    logic              valid;
    logic              halt;
    logic              we;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } wb_t;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  wb_t               r_wb;
  wb_t               w_wb_nxt;
  logic              w_commit;
  logic [31:0]       r_retired;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic              w_byp_ok;
  logic              w_unused_bits;

  assign w_unused_bits = ^bus.EX_WB[180:40];

  // Next state and capture; a capture at the edge that commits a halt is dropped too.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_wb_nxt    = '0;
    if (r_state == RUN && r_wb.valid) begin
      w_commit = 1'b1;
      if (r_wb.halt) w_state_nxt = HALTED;
    end
    w_wb_nxt.data  = DATA_W'(bus.EX_WB[31:0]);
    w_wb_nxt.addr  = AW'(bus.EX_WB[36:32]);
    w_wb_nxt.we    = bus.EX_WB[37];
    w_wb_nxt.halt  = bus.EX_WB[38];
    w_wb_nxt.valid = bus.EX_WB[39] && (w_state_nxt == RUN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_wb      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wb    <= w_wb_nxt;
      if (w_commit) r_retired <= r_retired + 32'd1;
    end
  end

  // Register file; entry 0 is never written so it stays zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
    end else if (w_commit && r_wb.we && r_wb.addr != '0) begin
      r_regs[r_wb.addr] <= r_wb.data;
    end
  end

  assign w_byp_ok = r_wb.valid && r_wb.we && (r_wb.addr != '0);

  always_comb begin
    w_rd_a = r_regs[bus.rd_addr_a];
    if (bus.rd_addr_a == 5'd0)                        w_rd_a = '0;
    else if (w_byp_ok && AW'(bus.rd_addr_a) == r_wb.addr) w_rd_a = r_wb.data;
  end

  always_comb begin
    w_rd_b = r_regs[bus.rd_addr_b];
    if (bus.rd_addr_b == 5'd0)                        w_rd_b = '0;
    else if (w_byp_ok && AW'(bus.rd_addr_b) == r_wb.addr) w_rd_b = r_wb.data;
  end

  assign bus.rd_data_a = 32'(w_rd_a);
  assign bus.rd_data_b = 32'(w_rd_b);
  assign bus.wb_valid  = r_wb.valid;
  assign bus.wb_addr   = 5'(r_wb.addr);
  assign bus.wb_data   = 32'(r_wb.data);
  assign bus.halted    = (r_state == HALTED);
  assign bus.retired   = r_retired;
endmodule
